alu_multiciclo: RTL and testbench

Parametrised, handshaked execution unit for the RISC-V datapath: the next generation of the combinational single-cycle ALU. It adds a `WIDTH` parameter, the full RV32I/M-style operation set including an iterative shift-add multiplier, and registered results with status flags. It sits between the register-read stage and write-back. Upstream issues operands with a valid/ready handshake; downstream consumes the result and flags with a second valid/ready handshake.

---
 rtl/alu_multiciclo.sv | 164 ++++++++++++++++
 tb/tb_alu_multiciclo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: handshaked execution unit with registered result and flags.
// Single-cycle ops are computed at the accepting edge. MUL runs an iterative
// shift-add over exactly WIDTH cycles. The result is held in DONE until the
// consumer takes it.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// MUL   | shift-add multiply in progress, one partial product per cycle
// DONE  | out_valid=1, result/flags frozen until out_ready
module alu_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] acc_next;

    // Single-cycle datapath, evaluated on the operands presented at accept.
    always_comb begin
        shamt   = B[SHW-1:0];
        sum_add = {1'b0, A} + {1'b0, B};
        // A + ~B + 1: the top bit is the no-borrow indication (A >= B unsigned).
        sum_sub = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (control)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_PASS: alu_res = B;
            default: alu_res = '0;
        endcase
    end

    // Next partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (control == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= A;
                            mplier <= B;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            neg       <= alu_res[WIDTH-1];
                            carry     <= alu_c;
                            overflow  <= alu_v;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        neg       <= acc_next[WIDTH-1];
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: directed cases plus random ops checked against an
// arithmetic reference model; a second WIDTH=8 instance covers the small case.
module tb_alu_multiciclo;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  A, B, result;
    logic [3:0]    control;
    logic          zero, neg, carry, overflow;

    logic          iv8, ir8, ov8, ordy8;
    logic [7:0]    a8, b8, res8;
    logic [3:0]    ctl8;
    logic          z8, n8, c8, v8;

    int n_checks = 0;
    int n_fail   = 0;

    alu_multiciclo #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .neg(neg), .carry(carry), .overflow(overflow)
    );

    alu_multiciclo #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .control(ctl8), .out_valid(ov8), .out_ready(ordy8),
        .result(res8), .zero(z8), .neg(n8), .carry(c8), .overflow(v8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the operation definitions using exact 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic z, output logic n,
                         output logic c, output logic v);
        longint unsigned ua, ub, full;
        longint          sa, sb, exact;
        int              sh;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                full  = ua + ub;
                res   = full[W-1:0];
                c     = (full > 64'hFFFF_FFFF);
                exact = sa + sb;
                v     = (exact != longint'($signed(res)));
            end
            4'd1: begin
                res   = a - b;
                c     = (ua >= ub);
                exact = sa - sb;
                v     = (exact != longint'($signed(res)));
            end
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = a ^ b;
            4'd5:  res = a << sh;
            4'd6:  res = a >> sh;
            4'd7: begin
                exact = sa / (64'sd1 << sh);
                if (sa < 0 && (sa % (64'sd1 << sh)) != 0) exact = exact - 1;
                res = exact[W-1:0];
            end
            4'd8:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  res = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: res = b;
            4'd11: begin
                full = ua * ub;
                res  = full[W-1:0];
            end
            default: res = '0;
        endcase
        z = (res == 0);
        n = res[W-1];
    endtask

    // Issue one op, hold out_ready low for 'hold' extra cycles, check everything.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic [W-1:0] er;
        logic ez, en, ec, ev;
        int lat;
        bit busy_ok;
        model(op, a, b, er, ez, en, ec, ev);
        @(negedge clk);
        in_valid = 1'b1; A = a; B = b; control = op; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; control = 4'($urandom);
        check_val("in_ready_after_accept", 64'(in_ready), 64'd0);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < W + 10) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom);
            A = $urandom; B = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check_val("latency", 64'(lat), (op == 4'd11) ? 64'(W + 1) : 64'd1);
        check_val("in_ready_busy", 64'(busy_ok), 64'd1);
        check_val("result", 64'(result), 64'(er));
        check_val("flags_zncv", {60'd0, zero, neg, carry, overflow}, {60'd0, ez, en, ec, ev});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_result", 64'(result), 64'(er));
            check_val("hold_flags", {60'd0, zero, neg, carry, overflow}, {60'd0, ez, en, ec, ev});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("release_valid", 64'(out_valid), 64'd0);
        check_val("release_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; control = '0;
        iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; ctl8 = '0;
        #12;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_result", 64'(result), 64'd0);
        check_val("rst_flags", {60'd0, zero, neg, carry, overflow}, 64'd0);
        check_val("rst_out_valid8", 64'(ov8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd1,  32'd5, 32'd5, 0);
        run_op(4'd1,  32'd0, 32'd1, 0);
        run_op(4'd7,  32'h8000_0000, 32'h0000_0024, 0);
        run_op(4'd6,  32'h8000_0000, 32'h0000_0024, 0);
        run_op(4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'd11, 32'h0000_FFFF, 32'h0001_0001, 0);
        run_op(4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 3);
        run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op(4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 0);
        run_op(4'd10, 32'hDEAD_BEEF, 32'h0000_0000, 0);

        for (int k = 0; k < 200; k++)
            run_op(4'($urandom), pick(), pick(), int'($urandom % 3));

        // Abort a multiply by reset partway through.
        @(negedge clk);
        in_valid = 1'b1; A = 32'h0000_FFFF; B = 32'h0001_0001; control = 4'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", 64'(out_valid), 64'd0);
        check_val("abort_in_ready", 64'(in_ready), 64'd1);
        check_val("abort_result", 64'(result), 64'd0);
        check_val("abort_flags", {60'd0, zero, neg, carry, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_val("abort_no_valid", 64'(seen), 64'd0);
        run_op(4'd0, 32'd2, 32'd3, 0);

        // WIDTH=8 instance: 0x0F * 0x11 = 0xFF after WIDTH+1 cycles.
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h0F; b8 = 8'h11; ctl8 = 4'd11;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 1;
        while (!ov8 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("w8_latency", 64'(lat), 64'd9);
        check_val("w8_result", 64'(res8), 64'hFF);
        check_val("w8_flags", {60'd0, z8, n8, c8, v8}, 64'b0100);
        check_val("w8_in_ready", 64'(ir8), 64'd0);
        @(negedge clk);
        ordy8 = 1'b1;
        @(posedge clk); #1;
        ordy8 = 1'b0;
        check_val("w8_release", 64'(ir8), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
